// File: rtl/instr_encoder.sv
// Instruction encoder / program loader.
// Accepts decoded instruction fields one beat at a time, packs them into
// 32-bit RV32-style words and writes them to consecutive word addresses of an
// instruction memory, starting at a word-aligned base address.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; base pointer, count and err latched on start
// LOAD   | accepting beats (in_ready=1); legal beats become one write each
// FINISH | one-cycle done pulse after the beat carrying in_last
module instr_encoder #(
    parameter int CNT_W     = 16,
    parameter int MAX_WORDS = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_op,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    input  logic             in_last,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic [CNT_W-1:0] count,
    output logic             done,
    output logic             err
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ALU    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALU_R  = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              rst_meta_q, rst_ok_q;
    logic [31:0]       ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              err_q;
    logic              imem_we_q;
    logic [31:0]       imem_addr_q;
    logic [31:0]       imem_wdata_q;

    logic              op_legal;
    logic              align_bad;
    logic              mem_full;
    logic              beat_acc;
    logic              write_ok;
    logic              beat_bad;
    logic [31:0]       enc_word;
    logic              unused_base_lsb;

    // The byte-offset bits of the base address are forced to zero.
    assign unused_base_lsb = ^base_addr[1:0];

    // Reset release synchroniser: assertion is immediate, release takes two edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_q <= 1'b0;
            rst_ok_q   <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_ok_q   <= rst_meta_q;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a dropped last beat still ends the load.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_LOAD;
            S_LOAD:   if (beat_acc && in_last) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (!rst_ok_q) begin
            state_d = S_IDLE;
        end
    end

    // State-decoded outputs.
    always_comb begin
        in_ready = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_LOAD:   in_ready = 1'b1;
            S_FINISH: done     = 1'b1;
            default:  ;
        endcase
    end

    // Opcode decode and field packing for the current beat.
    always_comb begin
        op_legal = 1'b1;
        enc_word = 32'h0;
        case (in_op)
            OP_LOAD, OP_ALU, OP_JALR:
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
            OP_STORE:
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op};
            OP_ALU_R:
                enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
            OP_LUI:
                enc_word = {in_imm[31:12], in_rd, in_op};
            OP_BRANCH:
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_op};
            OP_JAL:
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
            default:
                op_legal = 1'b0;
        endcase
    end

    // Branch/jump targets must be halfword aligned; memory must have room.
    assign align_bad = ((in_op == OP_BRANCH) || (in_op == OP_JAL)) && in_imm[0];
    assign mem_full  = (count_q >= MAX_CNT);
    assign beat_acc  = in_valid && in_ready;
    assign write_ok  = beat_acc && op_legal && !align_bad && !mem_full;
    assign beat_bad  = beat_acc && !write_ok;

    // Write pointer, word count, error flag and registered memory write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= 32'h0;
            count_q      <= '0;
            err_q        <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= 32'h0;
            imem_wdata_q <= 32'h0;
        end else if (!rst_ok_q) begin
            ptr_q        <= 32'h0;
            count_q      <= '0;
            err_q        <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= 32'h0;
            imem_wdata_q <= 32'h0;
        end else begin
            imem_we_q <= write_ok;
            if ((state_q == S_IDLE) && start) begin
                ptr_q   <= {base_addr[31:2], 2'b00};
                count_q <= '0;
                err_q   <= 1'b0;
            end
            if (write_ok) begin
                imem_addr_q  <= ptr_q;
                imem_wdata_q <= enc_word;
                ptr_q        <= ptr_q + 32'd4;
                count_q      <= count_q + CNT_ONE;
            end
            if (beat_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign count      = count_q;
    assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed programs with literal
// expected words plus randomized programs checked against a behavioural model.
module tb_instr_encoder;

    localparam int CNT_W = 16;
    localparam int MAXW  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = 32'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_op = 7'h0;
    logic [4:0]  in_rd = 5'h0, in_rs1 = 5'h0, in_rs2 = 5'h0;
    logic [2:0]  in_funct3 = 3'h0;
    logic [6:0]  in_funct7 = 7'h0;
    logic [31:0] in_imm = 32'h0;
    logic        in_last = 1'b0;
    logic        imem_we;
    logic [31:0] imem_addr, imem_wdata;
    logic [CNT_W-1:0] count;
    logic        done, err;

    int total = 0;
    int bad   = 0;

    instr_encoder #(.CNT_W(CNT_W), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .count(count), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic is_legal(input logic [6:0] op);
        return op inside {7'h03, 7'h13, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};
    endfunction

    // Word layout computed arithmetically from the field placement rules.
    function automatic logic [31:0] ref_enc(input logic [6:0] op, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [31:0] imm);
        logic [31:0] base;
        base = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        case (op)
            7'h03, 7'h13, 7'h67:
                return ((imm & 32'hFFF) << 20) | base | (32'(rd) << 7);
            7'h23:
                return (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | base | ((imm & 32'h1F) << 7);
            7'h33:
                return (32'(f7) << 25) | (32'(rs2) << 20) | base | (32'(rd) << 7);
            7'h37:
                return (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
            7'h63:
                return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
                       (32'(rs2) << 20) | base | (((imm >> 1) & 32'hF) << 8) |
                       (((imm >> 11) & 32'h1) << 7);
            7'h6F:
                return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                       (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) |
                       (32'(rd) << 7) | 32'(op);
            default: return 32'h0;
        endcase
    endfunction

    // Behavioural model: mode 0 idle, 1 loading, 2 finishing.
    int          m_mode;
    int          m_cnt;
    logic [31:0] m_ptr;
    logic        m_err;
    logic        exp_we;
    logic [31:0] exp_addr, exp_wdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_cnt = 0; m_ptr = 32'h0; m_err = 1'b0;
            exp_we = 1'b0; exp_addr = 32'h0; exp_wdata = 32'h0;
        end else begin
            exp_we = 1'b0;
            case (m_mode)
                0: if (start) begin
                    m_mode = 1; m_ptr = base_addr & 32'hFFFFFFFC; m_cnt = 0; m_err = 1'b0;
                end
                1: if (in_valid) begin
                    if (is_legal(in_op) && !((in_op == 7'h63 || in_op == 7'h6F) && in_imm[0])
                        && m_cnt < MAXW) begin
                        exp_we    = 1'b1;
                        exp_addr  = m_ptr;
                        exp_wdata = ref_enc(in_op, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
                        m_ptr     = m_ptr + 32'd4;
                        m_cnt     = m_cnt + 1;
                    end else begin
                        m_err = 1'b1;
                    end
                    if (in_last) m_mode = 2;
                end
                default: m_mode = 0;
            endcase
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(m_mode == 1));
        chk("done", 32'(done), 32'(m_mode == 2));
        chk("imem_we", 32'(imem_we), 32'(exp_we));
        chk("imem_addr", imem_addr, exp_addr);
        if (exp_we) chk("imem_wdata", imem_wdata, exp_wdata);
        chk("count", 32'(count), 32'(m_cnt));
        chk("err", 32'(err), 32'(m_err));
    end

    task automatic do_start(input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; base_addr = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic beat(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic last);
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    logic [6:0] legal_ops [8] = '{7'h03, 7'h13, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};

    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        idle(5);

        // Single ALU beat.
        do_start(32'h0000_0101);
        beat(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
        chk("t1_we", 32'(imem_we), 32'd1);
        chk("t1_addr", imem_addr, 32'h100);
        chk("t1_wdata", imem_wdata, 32'h00500093);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_count", 32'(count), 32'd1);
        idle(1);
        chk("t1_done_off", 32'(done), 32'd0);
        idle(2);

        // Four back-to-back beats of different formats.
        do_start(32'h100);
        beat(7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b0);
        chk("t2_lui_addr", imem_addr, 32'h100);
        chk("t2_lui_data", imem_wdata, 32'h12345137);
        beat(7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'd8, 1'b0);
        chk("t2_sw_addr", imem_addr, 32'h104);
        chk("t2_sw_data", imem_wdata, 32'h00312423);
        beat(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFF8, 1'b0);
        chk("t2_beq_addr", imem_addr, 32'h108);
        chk("t2_beq_data", imem_wdata, 32'hFE208CE3);
        beat(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 1'b1);
        chk("t2_jal_addr", imem_addr, 32'h10C);
        chk("t2_jal_data", imem_wdata, 32'h001000EF);
        chk("t2_count", 32'(count), 32'd4);
        idle(3);

        // Illegal opcode between two legal beats.
        do_start(32'h200);
        beat(7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0);
        beat(7'h7F, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0);
        chk("t3_drop_we", 32'(imem_we), 32'd0);
        beat(7'h33, 5'd5, 5'd6, 5'd7, 3'd0, 7'h20, 32'd0, 1'b1);
        chk("t3_addr", imem_addr, 32'h204);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_count", 32'(count), 32'd2);
        idle(3);

        // Misaligned JAL as the last beat.
        do_start(32'h300);
        beat(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b1);
        chk("t4_we", 32'(imem_we), 32'd0);
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_done", 32'(done), 32'd1);
        idle(3);

        // Capacity overflow with MAX_WORDS beats already written.
        do_start(32'h400);
        for (int i = 0; i < MAXW + 1; i++)
            beat(7'h13, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i), (i == MAXW) ? 1'b1 : 1'b0);
        chk("t5_count", 32'(count), 32'(MAXW));
        chk("t5_err", 32'(err), 32'd1);
        idle(3);

        // Reset mid-stream.
        do_start(32'h500);
        beat(7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd7, 1'b0);
        beat(7'h13, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 32'd9, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_ready", 32'(in_ready), 32'd0);
        chk("t6_we", 32'(imem_we), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_err", 32'(err), 32'd0);
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_addr", imem_addr, 32'h0);
        chk("t6_wdata", imem_wdata, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle(5);
        chk("t6_ready_after", 32'(in_ready), 32'd0);

        // Randomized programs, including pointer wrap near the top of memory.
        for (int p = 0; p < 60; p++) begin
            logic [31:0] b;
            int n;
            b = ($urandom % 4 == 0) ? (32'hFFFFFFF0 | 32'($urandom % 16)) : $urandom;
            n = $urandom_range(1, 7);
            if ($urandom % 3 == 0) begin
                in_valid = 1'b1; in_op = 7'h13;
            end
            do_start(b);
            for (int k = 0; k < n; k++) begin
                logic [6:0] op;
                logic [31:0] imm;
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0; in_op = 7'($urandom);
                    start = ($urandom % 4 == 0);
                    @(negedge clk);
                end
                start = ($urandom % 4 == 0);
                op  = ($urandom % 6 == 0) ? 7'($urandom) : legal_ops[$urandom % 8];
                imm = $urandom;
                if ($urandom % 4 != 0) imm[0] = 1'b0;
                beat(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                     7'($urandom), imm, (k == n - 1) ? 1'b1 : 1'b0);
            end
            start = 1'b0;
            idle($urandom_range(1, 3));
        end

        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
